// File: rtl/nrisc_dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_dmem_responder_pkg
// Shared constants for the NRISC_UP data-memory responder:
//   - control-bit positions of DDATA_CORE_ctrl
//   - byte-lane width and wait-counter width
//   - FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package nrisc_dmem_responder_pkg;

    // DDATA_CORE_ctrl bit positions
    localparam int CTRL_BYTE  = 0;   // 1 = byte access, 0 = word access
    localparam int CTRL_HI    = 1;   // byte access selects the high lane [15:8]
    localparam int CTRL_SEXT  = 2;   // byte load is sign-extended
    localparam int CTRL_W     = 3;

    localparam int LANE_W     = 8;   // one byte lane
    localparam int WAIT_CNT_W = 4;   // wait states range 0..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Terminal value of the wait counter; a zero wait count never enters
    // the WAIT state, so its terminal value is irrelevant.
    function automatic logic [WAIT_CNT_W-1:0] wait_last(input int wait_states);
        int last;
        last = (wait_states > 0) ? wait_states - 1 : 0;
        return WAIT_CNT_W'(last);
    endfunction

endpackage

// File: rtl/nrisc_dmem_responder_sram.sv
// -----------------------------------------------------------------------------
// nrisc_dmem_responder_sram
// Single-port synchronous word array (1 read/write port), TAM x 2**N_DData.
// Read is registered: dout reflects the word at addr sampled on the previous
// rising edge (old data on a same-address write). Contents are not reset.
// Ports:
//   clk   in   1        clock
//   we    in   1        write enable
//   addr  in   N_DData  word address
//   din   in   TAM      write data
//   dout  out  TAM      registered read data
// -----------------------------------------------------------------------------
module nrisc_dmem_responder_sram #(
    parameter int TAM     = 16,
    parameter int N_DData = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [N_DData-1:0] addr,
    input  logic [TAM-1:0]     din,
    output logic [TAM-1:0]     dout
);

    logic [TAM-1:0] mem_reg [0:(2**N_DData)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= din;
        end
        dout <= mem_reg[addr];
    end

endmodule

// File: rtl/nrisc_dmem_responder.sv
// -----------------------------------------------------------------------------
// nrisc_dmem_responder
// Memory-side responder for the NRISC_UP data bus. Serves core loads/stores
// from an on-chip word array with WAIT_STATES programmable wait cycles and
// byte-lane access (byte store = read-modify-write, byte load = zero/sign
// extension).
//
// Optional feature: define NRISC_DMEM_MMIO_EN to map the all-ones address to
// a memory-mapped I/O register pair (MMIO_out written by stores, MMIO_in
// returned by loads). Without it, the all-ones address is an ordinary word.
//
// Ports:
//   clk               in   1        clock, rising edge
//   rst               in   1        synchronous active-high reset
//   DDATA_CORE_addr   in   N_DData  word address
//   DDATA_CORE_in     in   TAM      store data
//   DDATA_CORE_load   in   1        load request (held until ready)
//   DDATA_CORE_write  in   1        store request (held until ready)
//   DDATA_CORE_ctrl   in   3        [0] byte, [1] high lane, [2] sign-extend
//   DDATA_CORE_out    out  TAM      registered load data, held between loads
//   DDATA_CORE_ready  out  1        one-cycle completion pulse
//   DDATA_CORE_err    out  1        one-cycle pulse with ready: load&write seen
//   MMIO_out          out  TAM      (NRISC_DMEM_MMIO_EN only) output register
//   MMIO_in           in   TAM      (NRISC_DMEM_MMIO_EN only) input port
//
// Timing: a request sampled at edge k produces ready in the cycle after edge
// k+1+WAIT_STATES. The array is read on edge k using the live core address
// (and re-read from the latched address while waiting), so the read word is
// ready when the RESP edge merges/extends it.
// -----------------------------------------------------------------------------
module nrisc_dmem_responder
    import nrisc_dmem_responder_pkg::*;
#(
    parameter int TAM         = 16,
    parameter int N_DData     = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DData-1:0] DDATA_CORE_addr,
    input  logic [TAM-1:0]     DDATA_CORE_in,
    input  logic               DDATA_CORE_load,
    input  logic               DDATA_CORE_write,
    input  logic [CTRL_W-1:0]  DDATA_CORE_ctrl,
    output logic [TAM-1:0]     DDATA_CORE_out,
    output logic               DDATA_CORE_ready,
    output logic               DDATA_CORE_err
`ifdef NRISC_DMEM_MMIO_EN
    ,
    output logic [TAM-1:0]     MMIO_out,
    input  logic [TAM-1:0]     MMIO_in
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = wait_last(WAIT_STATES);

    dmem_state_t             state_reg;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
    logic [N_DData-1:0]      addr_reg;
    logic [TAM-1:0]          data_reg;
    logic [CTRL_W-1:0]       ctrl_reg;
    logic                    store_reg;   // latched op: 1 = store
    logic                    both_reg;    // load and write were both asserted
    logic [TAM-1:0]          out_reg;
    logic                    ready_reg;
    logic                    err_reg;

    logic [N_DData-1:0]      ram_addr;
    logic [TAM-1:0]          ram_dout;
    logic                    ram_we;
    logic                    is_io;
    logic [TAM-1:0]          old_word;    // current contents of the store target
    logic [TAM-1:0]          load_word;   // word a load returns before extension
    logic [LANE_W-1:0]       load_byte;
    logic [TAM-1:0]          load_ext;
    logic [TAM-1:0]          store_merged;

    // In IDLE the array is addressed straight from the core so the read
    // completes on the accepting edge; afterwards the latched copy is used.
    assign ram_addr = (state_reg == ST_IDLE) ? DDATA_CORE_addr : addr_reg;

    // Reset gates the write so a store caught in RESP is discarded.
    assign ram_we = (state_reg == ST_RESP) && store_reg && !is_io && !rst;

    nrisc_dmem_responder_sram #(
        .TAM     (TAM),
        .N_DData (N_DData)
    ) u_sram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (store_merged),
        .dout (ram_dout)
    );

`ifdef NRISC_DMEM_MMIO_EN
    logic [TAM-1:0] mmio_out_reg;

    assign is_io     = (addr_reg == {N_DData{1'b1}});
    assign old_word  = is_io ? mmio_out_reg : ram_dout;
    assign load_word = is_io ? MMIO_in      : ram_dout;
    assign MMIO_out  = mmio_out_reg;
`else
    assign is_io     = 1'b0;
    assign old_word  = ram_dout;
    assign load_word = ram_dout;
`endif

    // Lane merge for stores and lane select/extension for loads.
    always_comb begin
        load_byte = ctrl_reg[CTRL_HI] ? load_word[2*LANE_W-1:LANE_W]
                                      : load_word[LANE_W-1:0];
        if (ctrl_reg[CTRL_BYTE]) begin
            load_ext = {{(TAM-LANE_W){ctrl_reg[CTRL_SEXT] & load_byte[LANE_W-1]}},
                        load_byte};
        end else begin
            load_ext = load_word;
        end

        store_merged = old_word;
        if (!ctrl_reg[CTRL_BYTE]) begin
            store_merged = data_reg;
        end else if (ctrl_reg[CTRL_HI]) begin
            store_merged[2*LANE_W-1:LANE_W] = data_reg[LANE_W-1:0];
        end else begin
            store_merged[LANE_W-1:0] = data_reg[LANE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            ctrl_reg     <= '0;
            store_reg    <= 1'b0;
            both_reg     <= 1'b0;
            out_reg      <= '0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
`ifdef NRISC_DMEM_MMIO_EN
            mmio_out_reg <= '0;
`endif
        end else begin
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (DDATA_CORE_load || DDATA_CORE_write) begin
                        addr_reg     <= DDATA_CORE_addr;
                        data_reg     <= DDATA_CORE_in;
                        ctrl_reg     <= DDATA_CORE_ctrl;
                        // Simultaneous load and write is executed as a store.
                        store_reg    <= DDATA_CORE_write;
                        both_reg     <= DDATA_CORE_load & DDATA_CORE_write;
                        wait_cnt_reg <= '0;
                        state_reg    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= ST_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    ready_reg    <= 1'b1;
                    err_reg      <= both_reg;
                    wait_cnt_reg <= '0;
                    if (!store_reg) begin
                        out_reg <= load_ext;
                    end
`ifdef NRISC_DMEM_MMIO_EN
                    else if (is_io) begin
                        mmio_out_reg <= store_merged;
                    end
`endif
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign DDATA_CORE_out   = out_reg;
    assign DDATA_CORE_ready = ready_reg;
    assign DDATA_CORE_err   = err_reg;

endmodule

// File: tb/tb_nrisc_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_nrisc_dmem_responder
// Two responders share address/data/ctrl/reset: dut1 with one wait state and
// dut0 with none. Each access pushes its expected data, err flag and ready
// cycle into a per-DUT queue; a monitor per DUT pops and compares whenever
// ready is seen. Defining NRISC_DMEM_MMIO_EN also exercises the I/O port.
// -----------------------------------------------------------------------------
module tb_nrisc_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [2:0]  ctrl;
    logic        load0, write0, load1, write1;
    logic [15:0] out0, out1;
    logic        ready0, ready1, err0, err1;
`ifdef NRISC_DMEM_MMIO_EN
    logic [15:0] mmio_out0, mmio_out1, mmio_in;
`endif

    always #5 clk = ~clk;

    nrisc_dmem_responder #(.TAM(16), .N_DData(8), .WAIT_STATES(0)) dut0 (
        .clk              (clk),
        .rst              (rst),
        .DDATA_CORE_addr  (addr),
        .DDATA_CORE_in    (din),
        .DDATA_CORE_load  (load0),
        .DDATA_CORE_write (write0),
        .DDATA_CORE_ctrl  (ctrl),
        .DDATA_CORE_out   (out0),
        .DDATA_CORE_ready (ready0),
        .DDATA_CORE_err   (err0)
`ifdef NRISC_DMEM_MMIO_EN
        ,
        .MMIO_out         (mmio_out0),
        .MMIO_in          (mmio_in)
`endif
    );

    nrisc_dmem_responder #(.TAM(16), .N_DData(8), .WAIT_STATES(1)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .DDATA_CORE_addr  (addr),
        .DDATA_CORE_in    (din),
        .DDATA_CORE_load  (load1),
        .DDATA_CORE_write (write1),
        .DDATA_CORE_ctrl  (ctrl),
        .DDATA_CORE_out   (out1),
        .DDATA_CORE_ready (ready1),
        .DDATA_CORE_err   (err1)
`ifdef NRISC_DMEM_MMIO_EN
        ,
        .MMIO_out         (mmio_out1),
        .MMIO_in          (mmio_in)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] last0, last1;   // value DDATA_CORE_out must hold

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon0
        exp_t e;
        if (err0 === 1'b1 && ready0 !== 1'b1)
            check("dut0 err without ready", 32'(ready0), 32'd1);
        if (ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut0 unexpected ready: actual=1 required=0 at cyc %0d", cyc);
            end else begin
                e = q0.pop_front();
                $display("[TB] dut0 %s out=%h err=%b cyc=%0d", e.name, out0, err0, cyc);
                check({"dut0 ", e.name, " latency"}, 32'(cyc), 32'(e.cyc));
                check({"dut0 ", e.name, " out"}, 32'(out0), 32'(e.out));
                check({"dut0 ", e.name, " err"}, 32'(err0), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (err1 === 1'b1 && ready1 !== 1'b1)
            check("dut1 err without ready", 32'(ready1), 32'd1);
        if (ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut1 unexpected ready: actual=1 required=0 at cyc %0d", cyc);
            end else begin
                e = q1.pop_front();
                $display("[TB] dut1 %s out=%h err=%b cyc=%0d", e.name, out1, err1, cyc);
                check({"dut1 ", e.name, " latency"}, 32'(cyc), 32'(e.cyc));
                check({"dut1 ", e.name, " out"}, 32'(out1), 32'(e.out));
                check({"dut1 ", e.name, " err"}, 32'(err1), 32'(e.err));
            end
        end
    end

    // ---------------- driver ----------------
    // Request starts just after an edge (cyc = c); accepted at edge c+1,
    // so ready is seen with cyc = c + 2 + WAIT_STATES.
    task automatic access(input int d, input logic ld, input logic wr,
                          input logic [7:0] a, input logic [15:0] dat,
                          input logic [2:0] c, input logic [15:0] eo, input string nm);
        exp_t e;
        int   n;
        logic rdy;
        @(posedge clk); #1;
        addr = a; din = dat; ctrl = c;
        e.name = nm; e.out = eo; e.err = ld & wr;
        e.cyc  = cyc + 2 + ((d == 1) ? 1 : 0);
        if (d == 0) begin load0 = ld; write0 = wr; q0.push_back(e); end
        else        begin load1 = ld; write1 = wr; q1.push_back(e); end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (d == 0) ? ready0 : ready1;
            if (rdy === 1'b1) break;
            n++;
            if (n > 40) begin
                tests++; fails++;
                $display("FAIL %s timeout: actual=no ready required=ready within 40 cycles", nm);
                break;
            end
        end
        // Core drops the request in the ready cycle.
        load0 = 1'b0; write0 = 1'b0; load1 = 1'b0; write1 = 1'b0;
    endtask

    task automatic st(input int d, input logic [7:0] a, input logic [15:0] dat,
                      input logic [2:0] c, input string nm);
        access(d, 1'b0, 1'b1, a, dat, c, (d == 0) ? last0 : last1, nm);
    endtask

    task automatic ld(input int d, input logic [7:0] a, input logic [2:0] c,
                      input logic [15:0] eo, input string nm);
        if (d == 0) last0 = eo; else last1 = eo;
        access(d, 1'b1, 1'b0, a, 16'h0000, c, eo, nm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int   n;
        exp_t e;
        rst = 1'b1; addr = '0; din = '0; ctrl = '0;
        load0 = 1'b0; write0 = 1'b0; load1 = 1'b0; write1 = 1'b0;
        last0 = 16'h0000; last1 = 16'h0000;
`ifdef NRISC_DMEM_MMIO_EN
        mmio_in = 16'h0000;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out1", 32'(out1), 32'h0);
        check("reset ready1", 32'(ready1), 32'h0);
        check("reset err1", 32'(err1), 32'h0);
        check("reset out0", 32'(out0), 32'h0);
        check("reset ready0", 32'(ready0), 32'h0);
`ifdef NRISC_DMEM_MMIO_EN
        check("reset mmio_out1", 32'(mmio_out1), 32'h0);
`endif

        // 1: word store / load, one wait state
        st(1, 8'h10, 16'h1234, 3'b000, "word store 1234@10");
        ld(1, 8'h10, 3'b000, 16'h1234, "word load @10");

        // 2: byte lanes
        st(1, 8'h10, 16'h00AB, 3'b011, "byte store hi AB@10");
        ld(1, 8'h10, 3'b000, 16'hAB34, "word load @10 after hi byte");
        ld(1, 8'h10, 3'b101, 16'h0034, "byte load lo sext");
        ld(1, 8'h10, 3'b111, 16'hFFAB, "byte load hi sext");
        ld(1, 8'h10, 3'b011, 16'h00AB, "byte load hi zext");
        st(1, 8'h10, 16'h99CD, 3'b001, "byte store lo CD@10");
        ld(1, 8'h10, 3'b110, 16'hABCD, "word load ignores ctrl hi/sext");
        ld(1, 8'h10, 3'b101, 16'hFFCD, "byte load lo sext neg");

        // 4: load & write together -> store with err; out holds last load
        access(1, 1'b1, 1'b1, 8'h20, 16'h5A5A, 3'b000, last1, "load+write 5A5A@20");
        ld(1, 8'h20, 3'b000, 16'h5A5A, "word load @20");

        // 3: zero wait states, request held across back-to-back accesses
        st(0, 8'h01, 16'h0A0A, 3'b000, "store 0A0A@01");
        st(0, 8'h02, 16'h0B0B, 3'b000, "store 0B0B@02");
        @(posedge clk); #1;
        addr = 8'h01; ctrl = 3'b000; load0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.name = "held load";
            e.out  = (i % 2 == 0) ? 16'h0A0A : 16'h0B0B;
            e.err  = 1'b0;
            e.cyc  = cyc + 2 + 2 * i;
            q0.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (ready0 === 1'b1) break;
                n++;
                if (n > 20) begin
                    tests++; fails++;
                    $display("FAIL held load timeout: actual=no ready required=ready");
                    break;
                end
            end
            if (i == 3) load0 = 1'b0;
            else addr = (addr == 8'h01) ? 8'h02 : 8'h01;
        end
        last0 = 16'h0B0B;
        ld(0, 8'h01, 3'b000, 16'h0A0A, "single load @01 ws0");

        // 5: reset in WAIT and in RESP discards the pending store
        st(1, 8'h30, 16'h1111, 3'b000, "store 1111@30");
        @(posedge clk); #1;
        addr = 8'h30; din = 16'hBEEF; ctrl = 3'b000; write1 = 1'b1;
        @(posedge clk); #1;          // accepted, now waiting
        rst = 1'b1; write1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        din = 16'hCAFE; write1 = 1'b1;
        @(posedge clk); #1;          // accepted
        write1 = 1'b0;
        @(posedge clk); #1;          // now in RESP
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last0 = 16'h0000; last1 = 16'h0000;
        @(negedge clk);
        check("out1 cleared by mid-access reset", 32'(out1), 32'h0);
        ld(1, 8'h30, 3'b000, 16'h1111, "load @30 after aborted stores");

        // 6: top address
`ifdef NRISC_DMEM_MMIO_EN
        mmio_in = 16'h1357;
        st(1, 8'hFF, 16'h00FF, 3'b000, "mmio word store 00FF");
        check("mmio_out after word store", 32'(mmio_out1), 32'h00FF);
        st(1, 8'hFF, 16'h0012, 3'b011, "mmio hi byte store 12");
        check("mmio_out after hi byte store", 32'(mmio_out1), 32'h12FF);
        ld(1, 8'hFF, 3'b000, 16'h1357, "mmio word load");
        ld(1, 8'hFF, 3'b111, 16'h0013, "mmio byte load hi sext");
`else
        st(1, 8'hFF, 16'h7777, 3'b000, "store 7777@FF");
        st(1, 8'h00, 16'h0001, 3'b000, "store 0001@00");
        ld(1, 8'hFF, 3'b000, 16'h7777, "load @FF");
        ld(1, 8'h00, 3'b000, 16'h0001, "load @00");
`endif

        repeat (5) @(negedge clk);
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
